// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch path.
package instr_fetch_unit_pkg;

    localparam int              FETCH_ADDR_W     = 32;
    localparam int              FETCH_DATA_W     = 32;
    localparam int              INSTR_BYTES      = 4;
    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic in-order circular FIFO: push/pop/flush, head read is combinational, one-cycle write-to-visible.
// Push while full is legal only together with a pop; flush and reset empty it and take priority.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          push_dat_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_dat_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: pushes {pc, instr} into fetch_queue each cycle there is room; head valid the cycle after push.
// Decode backpressure stalls the PC when the queue is full; a redirect flushes and restarts fetch at the target.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = FETCH_ADDR_W,
    parameter int                    DATA_WIDTH  = FETCH_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  misalign_err
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  misalign_q, misalign_d;
    fetch_entry_t          last_q, last_d;
    fetch_entry_t          push_entry, head_entry;
    logic [CNT_W-1:0]      q_count;
    logic                  q_empty;
    logic                  push, pop;

    // A head shown during a redirect is discarded, never consumed.
    assign pop  = !q_empty && out_ready && !redirect_valid;
    assign push = fetch_en && !redirect_valid &&
                  ((q_count < CNT_W'(QUEUE_DEPTH)) || pop);

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = instr;

    fetch_queue #(
        .WIDTH (  $bits(fetch_entry_t)),
        .DEPTH (  QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .head_dat_o (head_entry),
        .count_o    (q_count),
        .empty_o    (q_empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        last_d     = last_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
        end
        if (pop) last_d = head_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
            last_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
            last_q     <= last_d;
        end
    end

    assign instr_addr   = fetch_pc_q;
    assign out_valid    = !q_empty;
    assign out_pc       = q_empty ? last_q.pc    : head_entry.pc;
    assign out_instr    = q_empty ? last_q.instr : head_entry.instr;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench: expected (pc, instr) streams are queued at reset/redirect and popped on each accepted head.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] instr_addr, instr, out_instr, out_pc;
    logic        out_valid, misalign_err;
    logic [31:0] instr_addr2, instr2, out_instr2, out_pc2;
    logic        out_valid2, misalign_err2;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign instr  = mem_word(instr_addr);
    assign instr2 = mem_word(instr_addr2);

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .instr_addr(instr_addr), .instr(instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .instr_addr(instr_addr2), .instr(instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2), .misalign_err(misalign_err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [31:0] start, input int n);
        exp_t e;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !redirect_valid && out_valid && out_ready) begin
            chk("sb_depth", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pop_pc", out_pc, mon_e.pc);
                chk("pop_instr", out_instr, mon_e.instr);
            end
        end
    end

    initial begin
        logic [31:0] wrap_pc [4];
        wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        cyc(2);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", instr_addr, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_addr_wrap", instr_addr2, 32'hFFFF_FFF8);

        // Streaming from reset: valid appears in the second cycle, then one per cycle.
        reset = 1'b0;
        sb_load(32'h0, 16);
        @(negedge clk);
        chk("t1_valid_c1", 32'(out_valid), 32'd0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid_stream", 32'(out_valid), 32'd1);
            cyc(1);
        end
        chk("t1_sb_left", 32'(sb.size()), 32'd12);

        // Backpressure: queue saturates, PC freezes, nothing lost or repeated.
        reset = 1'b1; out_ready = 1'b0;
        cyc(1);
        reset = 1'b0;
        sb_load(32'h0, 8);
        cyc(5);
        chk("t2_addr_frozen", instr_addr, 32'h8);
        chk("t2_valid_full", 32'(out_valid), 32'd1);
        chk("t2_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        cyc(4);
        chk("t2_sb_left", 32'(sb.size()), 32'd4);

        // Aligned redirect while full.
        out_ready = 1'b0;
        cyc(2);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        sb_load(32'h100, 8);
        cyc(1);
        redirect_valid = 1'b0;
        chk("t3_addr", instr_addr, 32'h100);
        @(negedge clk);
        chk("t3_valid_gap", 32'(out_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_pc", out_pc, 32'h100);
        chk("t3_instr", out_instr, 32'h1000_0040);
        chk("t3_misalign", 32'(misalign_err), 32'd0);
        cyc(1);

        // Misaligned redirect: aligned restart and sticky error.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        sb_load(32'h100, 8);
        cyc(1);
        redirect_valid = 1'b0;
        chk("t4_addr", instr_addr, 32'h100);
        chk("t4_misalign_set", 32'(misalign_err), 32'd1);
        cyc(2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        sb_load(32'h200, 8);
        cyc(1);
        redirect_valid = 1'b0;
        chk("t4_misalign_sticky", 32'(misalign_err), 32'd1);
        cyc(3);

        // fetch_en low: queue drains, PC holds.
        chk("t6_addr_pre", instr_addr, 32'h20C);
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t6_addr_hold", instr_addr, 32'h20C);
        end
        chk("t6_drained", 32'(out_valid), 32'd0);
        chk("t6_sb_left", 32'(sb.size()), 32'd5);

        // Reset together with a misaligned redirect: reset wins.
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0303; fetch_en = 1'b1;
        sb_load(32'h0, 8);
        cyc(1);
        reset = 1'b0; redirect_valid = 1'b0;
        chk("t6_rst_addr", instr_addr, 32'h0);
        chk("t6_rst_misalign", 32'(misalign_err), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_addr", instr_addr2, 32'hFFFF_FFF8);

        // Address wrap on the instance with a high reset PC.
        @(negedge clk);
        chk("t5_valid_c1", 32'(out_valid2), 32'd0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_valid", 32'(out_valid2), 32'd1);
            chk("t5_pc", out_pc2, wrap_pc[i]);
            chk("t5_instr", out_instr2, mem_word(wrap_pc[i]));
            cyc(1);
        end
        chk("t5_sb_left", 32'(sb.size()), 32'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
